// File: rtl/stopwatch_disp_pkg.sv
// stopwatch_disp_pkg: shared digit width and active-low 7-segment glyphs for display blocks
package stopwatch_disp_pkg;
    localparam int BCD_W = 4;
    localparam logic [6:0] SEG_GLYPH [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: 4-bit code to active-low segments; non-decimal codes render as a dash
module bcd_to_seg7 import stopwatch_disp_pkg::*; (
    input  logic [BCD_W-1:0] code_i,
    output logic [6:0]       seg_o
);
    assign seg_o = code_i < 4'd10 ? SEG_GLYPH[code_i] : SEG_DASH;
endmodule

// File: rtl/stopwatch_display_scan.sv
// stopwatch_display_scan: frame-snapshotted, guarded multiplexing of BCD digits onto a common-anode display
module stopwatch_display_scan import stopwatch_disp_pkg::*; #(
    parameter int NUM_DIG     = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [BCD_W*NUM_DIG-1:0] run_digits,
    input  logic [BCD_W*NUM_DIG-1:0] lap_digits,
    input  logic                     show_lap,
    input  logic                     lz_blank,
    input  logic [NUM_DIG-1:0]       dp_mask,
    output logic [NUM_DIG-1:0]       an,
    output logic [6:0]               seg,
    output logic                     dp,
    output logic                     frame_tick
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIG);
    logic [PW-1:0] p_q, p_d;
    logic [IW-1:0] i_q, i_d;
    logic [BCD_W*NUM_DIG-1:0] snap_q;
    logic [NUM_DIG-1:0] dpm_q, blank;
    logic lz_q, first_q, lz_eff, lz_run, wrap, load;
    logic [BCD_W-1:0] cur;
    logic [6:0] glyph;
    assign wrap   = p_q == PW'(REFRESH_DIV - 1);
    assign load   = wrap && i_q == IW'(NUM_DIG - 1);
    assign p_d    = wrap ? '0 : p_q + 1'b1;
    assign i_d    = !wrap ? i_q : load ? '0 : i_q + 1'b1;
    assign cur    = snap_q[i_q*BCD_W +: BCD_W];
    // Nothing is latched before the first snapshot, so the live blanking input governs that frame.
    assign lz_eff = first_q ? lz_blank : lz_q;
    always_comb begin
        blank  = '0;
        lz_run = lz_eff;
        for (int k = NUM_DIG - 1; k >= 1; k--) begin
            lz_run   = lz_run && snap_q[k*BCD_W +: BCD_W] == '0;
            blank[k] = lz_run;
        end
    end
    bcd_to_seg7 u_dec (
        .code_i(cur),
        .seg_o (glyph)
    );
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            p_q        <= '0;
            i_q        <= '0;
            snap_q     <= '0;
            dpm_q      <= '0;
            lz_q       <= 1'b0;
            first_q    <= 1'b1;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            p_q        <= p_d;
            i_q        <= i_d;
            an         <= p_q < PW'(GUARD) ? '1 : ~(NUM_DIG'(1) << i_q);
            seg        <= blank[i_q] ? SEG_BLANK : glyph;
            dp         <= ~dpm_q[i_q];
            frame_tick <= load;
            if (load) begin
                snap_q  <= show_lap ? lap_digits : run_digits;
                dpm_q   <= dp_mask;
                lz_q    <= lz_blank;
                first_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_display_scan.sv
// tb_stopwatch_display_scan: cycle-count display model checked every cycle, plus pinned literal glyphs
module tb_stopwatch_display_scan;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int G  = 2;
    localparam int FR = ND * RD;
    logic clk = 1'b0;
    logic clr = 1'b1;
    logic [15:0] run_digits = '0, lap_digits = '0;
    logic show_lap = 1'b0, lz_blank = 1'b1;
    logic [3:0] dp_mask = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp, frame_tick;
    int vectors = 0, miscompares = 0;
    logic armed = 1'b0;
    int n;
    logic [15:0] snap_m, sh;
    logic [3:0] dpm_m;
    logic lz_m, first_m, blk;
    int p, i;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_ft;
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    stopwatch_display_scan #(.NUM_DIG(ND), .REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk(clk), .clr(clr), .run_digits(run_digits), .lap_digits(lap_digits),
        .show_lap(show_lap), .lz_blank(lz_blank), .dp_mask(dp_mask),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );
    always #5 clk = ~clk;
    // n = cycles since reset release; slot and digit follow from it by division.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            n = 0; snap_m = '0; dpm_m = '0; lz_m = 1'b0; first_m = 1'b1;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
        end else begin
            p = n % RD;
            i = (n / RD) % ND;
            sh = snap_m >> (4 * i);
            blk = i > 0 && (first_m ? lz_blank : lz_m) && sh == 16'h0;
            e_an = p < G ? 4'hF : ~(4'b1 << i);
            e_seg = blk ? 7'h7F : glyph[sh[3:0]];
            e_dp = ~dpm_m[i];
            e_ft = n % FR == FR - 1;
            if (e_ft) begin
                snap_m = show_lap ? lap_digits : run_digits;
                dpm_m = dp_mask;
                lz_m = lz_blank;
                first_m = 1'b0;
            end
            n++;
        end
    end
    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask
    always @(negedge clk) if (armed) begin
        cmp("an", 8'(an), 8'(e_an));
        cmp("seg", 8'(seg), 8'(e_seg));
        cmp("dp", 8'(dp), 8'(e_dp));
        cmp("frame_tick", 8'(frame_tick), 8'(e_ft));
    end
    task automatic go_to(input int s);
        int w = 0;
        while (n != s + 1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (n != s + 1) begin
            miscompares++;
            $display("FAIL go_to timeout: state %0d not reached, n=%0d", s, n);
        end
    endtask
    task automatic lit(input string nm, input logic [3:0] a, input logic [6:0] s);
        cmp({nm, "_an"}, 8'(an), 8'(a));
        cmp({nm, "_seg"}, 8'(seg), 8'(s));
    endtask
    initial begin
        repeat (3) @(negedge clk);
        armed = 1'b1;
        lit("reset", 4'hF, 7'h7F);
        cmp("reset_dp", 8'(dp), 8'h01);
        cmp("reset_ft", 8'(frame_tick), 8'h00);
        clr = 1'b0;
        go_to(0);  lit("f0_guard", 4'hF, 7'h40);
        go_to(2);  lit("f0_d0", 4'hE, 7'h40);
        go_to(10); lit("f0_d1_blank", 4'hD, 7'h7F);
        run_digits = 16'h1234; lz_blank = 1'b0;
        go_to(30); cmp("ft_before", 8'(frame_tick), 8'h00);
        go_to(31); cmp("ft_first", 8'(frame_tick), 8'h01);
        go_to(32); cmp("ft_after", 8'(frame_tick), 8'h00);
        go_to(33); cmp("guard_end", 8'(an), 8'h0F);
        go_to(34); lit("scan_d0", 4'hE, 7'h19);
        go_to(39); cmp("slot_end", 8'(an), 8'h0E);
        go_to(40); cmp("next_guard", 8'(an), 8'h0F);
        go_to(42); lit("scan_d1", 4'hD, 7'h30);
        go_to(50); lit("scan_d2", 4'hB, 7'h24);
        go_to(58); lit("scan_d3", 4'h7, 7'h79);
        run_digits = 16'h0059; lap_digits = 16'h0042; lz_blank = 1'b1;
        go_to(66); lit("run_d0", 4'hE, 7'h10);
        go_to(70); show_lap = 1'b1;
        go_to(74); lit("run_d1", 4'hD, 7'h12);
        go_to(82); lit("run_d2", 4'hB, 7'h7F);
        go_to(95); cmp("ft_f2", 8'(frame_tick), 8'h01);
        go_to(98); lit("lap_d0", 4'hE, 7'h24);
        go_to(106); lit("lap_d1", 4'hD, 7'h19);
        go_to(114); lit("lap_d2", 4'hB, 7'h7F);
        go_to(120); show_lap = 1'b0; lz_blank = 1'b0;
        go_to(127); cmp("ft_f3", 8'(frame_tick), 8'h01);
        for (int s = 128; s <= 159; s++) begin
            go_to(s - 1);
            run_digits = s == 159 ? 16'h9876 : 16'($urandom);
        end
        go_to(162); lit("tear_d0", 4'hE, 7'h02);
        go_to(170); lit("tear_d1", 4'hD, 7'h78);
        go_to(178); lit("tear_d2", 4'hB, 7'h00);
        go_to(186); lit("tear_d3", 4'h7, 7'h10);
        run_digits = 16'h1000; lz_blank = 1'b1;
        go_to(194); lit("k_d0", 4'hE, 7'h40);
        go_to(202); lit("k_d1", 4'hD, 7'h40);
        go_to(210); lit("k_d2", 4'hB, 7'h40);
        go_to(218); lit("k_d3", 4'h7, 7'h79);
        run_digits = 16'h00A5; dp_mask = 4'b0100;
        go_to(226); lit("a5_d0", 4'hE, 7'h12); cmp("a5_dp0", 8'(dp), 8'h01);
        go_to(234); lit("a5_d1", 4'hD, 7'h3F); cmp("a5_dp1", 8'(dp), 8'h01);
        go_to(242); lit("a5_d2", 4'hB, 7'h7F); cmp("a5_dp2", 8'(dp), 8'h00);
        go_to(250); lit("a5_d3", 4'h7, 7'h7F); cmp("a5_dp3", 8'(dp), 8'h01);
        run_digits = 16'h0000;
        go_to(258); lit("z_d0", 4'hE, 7'h40);
        go_to(266); lit("z_d1", 4'hD, 7'h7F);
        go_to(268); cmp("pre_clr_an", 8'(an), 8'h0D);
        #1 clr = 1'b1;
        #1 lit("async_clr", 4'hF, 7'h7F);
        cmp("async_clr_dp", 8'(dp), 8'h01);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        go_to(2);  lit("r_d0", 4'hE, 7'h40);
        go_to(10); lit("r_d1", 4'hD, 7'h7F);
        go_to(18); cmp("r_dp2", 8'(dp), 8'h01);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stopwatch_display_scan.md
# stopwatch_display_scan

Display-side consumer of the stopwatch digit counters. It reads the per-digit BCD counts, either the running count or the captured lap count, and drives a time-multiplexed, common-anode 7-segment display. The block snapshots the selected digits once per refresh frame so the display never shows a torn value. It also applies leading-zero blanking and decimal points, and inserts an anode guard interval at every digit change to suppress ghosting. It sits between the counter chain and the board display pins.

## Interface
- NUM_DIG, 4: number of display digits (2..8)
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz digit rate at 100 MHz); must be ≥ 4
- GUARD, 16: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-high
- run_digits  in  4*NUM_DIG  running BCD count; digit k at [4k+3:4k], digit 0 = least significant
- lap_digits  in  4*NUM_DIG  lap-captured BCD count, same packing
- show_lap  in  1  level; 1 selects lap_digits, 0 selects run_digits
- lz_blank  in  1  level; 1 enables leading-zero blanking
- dp_mask  in  NUM_DIG  bit k = 1 lights the decimal point of digit k
- an  out  NUM_DIG  anode enables, active-low
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g
- dp  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse on each snapshot load

## Operation
- Prescaler p counts 0..REFRESH_DIV-1 and wraps. Digit index i advances (i+1) mod NUM_DIG when p wraps.
- Snapshot: when p = REFRESH_DIV-1 and i = NUM_DIG-1, capture snap ← (show_lap ? lap_digits : run_digits) and dp_mask. frame_tick = 1 in the same cycle.
  - show_lap, lz_blank and digit changes mid-frame take effect only at the next snapshot.
  - lz_blank is sampled at the snapshot.
- Decode of snap digit i:
  - codes 0–9 produce the standard glyphs.
  - codes 10–15 produce "-" (g only).
- Blanking: digit k (k ≥ 1) is blanked when lz_blank = 1 and digits NUM_DIG-1..k are all 0. Digit 0 is never blanked.
  - A blanked digit drives seg = 7'h7F. Its dp still follows the mask.
- Anodes: an = all ones while p < GUARD. Otherwise an has only bit i low.
- seg/dp change only at slot boundaries, while the anodes are off.

## Timing
- All outputs are registered. an/seg/dp/frame_tick at cycle t+1 are functions of p, i and snap at cycle t; frame_tick is registered likewise.
- Frame period is NUM_DIG·REFRESH_DIV cycles.
- Reset values: p=0, i=0, snap=0, latched dp_mask=0, an=all ones, seg=7'h7F, dp=1, frame_tick=0.
- clr asserted mid-frame: all state returns to reset values immediately, with no partial glyph.
- First frame after reset shows snap=0: "0" on digit 0, remaining digits blanked if lz_blank=1, else all "0".
- The first real snapshot occurs at cycle NUM_DIG·REFRESH_DIV-1 after reset release.
- Guard: in every slot, an stays all ones for exactly GUARD cycles, then one anode is low for REFRESH_DIV-GUARD cycles.

## Structure
- Shared package stopwatch_disp_pkg holds:
  - the 7-bit segment constants for 0–9, dash and blank
  - the BCD digit width constant (4)
- Sub-module bcd_to_seg7: combinational 4-bit code → 7-bit active-low pattern, reused by other display blocks.
- Top contains the prescaler, index counter, snapshot register, blanking logic and output registers.

## Test plan
All scenarios use NUM_DIG=4, REFRESH_DIV=8, GUARD=2.
- Reset: hold clr during activity and release → an=4'hF, seg=7'h7F, dp=1, frame_tick=0. First frame: digit 0 shows 7'h40 ("0"); with lz_blank=1 digits 1–3 show 7'h7F.
- Scan order: run_digits=16'h1234, lz_blank=0, after the first snapshot → per slot, an sequence 4'hE,4'hD,4'hB,4'h7 with seg "4","3","2","1". Each slot is 2 cycles an=4'hF, then 6 cycles active.
- Lap select: run=16'h0059 and lap=16'h0042; toggle show_lap mid-frame → the current frame still shows 0059, the next frame shows 0042. frame_tick pulses once per 32 cycles.
- Tearing: change run_digits every cycle during a frame → displayed digits equal the value present at the frame_tick cycle.
- Blanking edges, lz_blank=1:
  - 16'h0000 → only digit 0 lit ("0").
  - 16'h1000 → all four lit ("1","0","0","0").
  - 16'h00A5 → digit 1 shows "-" (7'h3F), digits 2–3 blank.
- dp and mid-operation reset: dp_mask=4'b0100 → dp=0 only in the digit-2 slot, including when that digit is blanked. Assert clr in a slot's active phase → an=4'hF on the same edge.
